// File: rtl/approx_mul_pkg.sv
// Shared constants and helpers for the approximate pipelined multiplier.
// Level codes select how many low product bits of a quadrant are forced to zero.
package approx_mul_pkg;

    localparam logic [1:0] LVL_EXACT = 2'd0;
    localparam logic [1:0] LVL_1     = 2'd1;
    localparam logic [1:0] LVL_2     = 2'd2;
    localparam logic [1:0] LVL_3     = 2'd3;

    // Number of truncated low bits for an h-bit quadrant at the given level.
    function automatic int unsigned lvl_shift(input int unsigned h, input logic [1:0] lvl);
        int unsigned l;
        case (lvl)
            LVL_EXACT: l = 0;
            LVL_1:     l = h / 2;
            LVL_2:     l = h;
            default:   l = h + h / 2;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/approx_quad.sv
// One HxH unsigned quadrant multiplier whose low product bits are zeroed
// according to the requested approximation level.
module approx_quad
    import approx_mul_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W/2-1:0] x,
    input  logic [W/2-1:0] y,
    input  logic [1:0]     lvl,
    output logic [W-1:0]   p
);

    localparam int unsigned H = W / 2;

    logic [W-1:0] full;
    logic [W-1:0] mask;

    always_comb begin
        full = W'(x) * W'(y);
        mask = {W{1'b1}} << lvl_shift(H, lvl);
        p    = full & mask;
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage approximate multiplier: operand capture, masked quadrant products,
// then an exact or carry-free-middle final adder. One global stall enable.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [7:0]       lvl,
    input  logic             add_approx,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   prod,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned H = W / 2;

    logic en;

    // Stage 1: captured operation
    logic             s1_valid_q;
    logic [W-1:0]     s1_a_q;
    logic [W-1:0]     s1_b_q;
    logic [7:0]       s1_lvl_q;
    logic             s1_add_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 2: masked quadrant products
    logic             s2_valid_q;
    logic [W-1:0]     s2_ll_q, s2_lh_q, s2_hl_q, s2_hh_q;
    logic             s2_add_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic [W-1:0]     ll_d, lh_d, hl_d, hh_d;
    logic [2*W-1:0]   prod_d;
    logic [2*W-1:0]   sum_exact;
    logic [W-1:0]     sum_hi;
    logic [H-1:0]     sum_mid;

    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    approx_quad #(.W(W)) u_ll (
        .x   (s1_a_q[H-1:0]),
        .y   (s1_b_q[H-1:0]),
        .lvl (s1_lvl_q[1:0]),
        .p   (ll_d)
    );

    approx_quad #(.W(W)) u_lh (
        .x   (s1_a_q[H-1:0]),
        .y   (s1_b_q[W-1:H]),
        .lvl (s1_lvl_q[3:2]),
        .p   (lh_d)
    );

    approx_quad #(.W(W)) u_hl (
        .x   (s1_a_q[W-1:H]),
        .y   (s1_b_q[H-1:0]),
        .lvl (s1_lvl_q[5:4]),
        .p   (hl_d)
    );

    approx_quad #(.W(W)) u_hh (
        .x   (s1_a_q[W-1:H]),
        .y   (s1_b_q[W-1:H]),
        .lvl (s1_lvl_q[7:6]),
        .p   (hh_d)
    );

    // The inexact adder ORs the overlapping middle bits and drops their carry.
    always_comb begin
        sum_exact = (2*W)'(s2_ll_q) + ((2*W)'(s2_lh_q) << H) + ((2*W)'(s2_hl_q) << H)
                  + {s2_hh_q, {W{1'b0}}};
        sum_mid   = s2_ll_q[W-1:H] | s2_lh_q[H-1:0] | s2_hl_q[H-1:0];
        sum_hi    = s2_hh_q + W'(s2_lh_q[W-1:H]) + W'(s2_hl_q[W-1:H]);
        prod_d    = s2_add_q ? {sum_hi, sum_mid, s2_ll_q[H-1:0]} : sum_exact;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_lvl_q   <= '0;
            s1_add_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_ll_q    <= '0;
            s2_lh_q    <= '0;
            s2_hl_q    <= '0;
            s2_hh_q    <= '0;
            s2_add_q   <= 1'b0;
            s2_tag_q   <= '0;
            out_valid  <= 1'b0;
            prod       <= '0;
            out_tag    <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_a_q     <= a;
            s1_b_q     <= b;
            s1_lvl_q   <= lvl;
            s1_add_q   <= add_approx;
            s1_tag_q   <= in_tag;
            s2_valid_q <= s1_valid_q;
            s2_ll_q    <= ll_d;
            s2_lh_q    <= lh_d;
            s2_hl_q    <= hl_d;
            s2_hh_q    <= hh_d;
            s2_add_q   <= s1_add_q;
            s2_tag_q   <= s1_tag_q;
            out_valid  <= s2_valid_q;
            prod       <= prod_d;
            out_tag    <= s2_tag_q;
        end
    end

endmodule
